// File: rtl/lyra2_pkg.sv
// rtl/lyra2_pkg.sv - shared Lyra2 constants, FIFO thresholds and scheduler state type
package lyra2_pkg;

    localparam int DATA_WIDTH     = 256;
    localparam int PIPELINE_DEPTH = 8;

    // Almost-empty / almost-full fire one full batch away from the limit.
    localparam int IN_ALMOST_EMPTY_THRESH = PIPELINE_DEPTH;
    localparam int OUT_ALMOST_FULL_THRESH = PIPELINE_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/lyra2_batch_sched_if.sv
// rtl/lyra2_batch_sched_if.sv - FIFO, core and status signals of the batch scheduler
interface lyra2_batch_sched_if #(
    parameter int DATA_WIDTH = lyra2_pkg::DATA_WIDTH
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] in_fifo_dout;
    logic                  in_fifo_almost_empty;
    logic                  in_fifo_rd_en;
    logic                  core_in_valid;
    logic                  core_in_start;
    logic [DATA_WIDTH-1:0] core_in_data;
    logic                  core_out_valid;
    logic [DATA_WIDTH-1:0] core_out_data;
    logic                  out_fifo_almost_full;
    logic                  out_fifo_full;
    logic                  out_fifo_wr_en;
    logic [DATA_WIDTH-1:0] out_fifo_din;
    logic                  busy;
    logic [31:0]           batch_count;
    logic                  err_overflow;
    logic                  err_protocol;

    // master: the surrounding FIFOs, core and register block
    modport master (
        output enable, in_fifo_dout, in_fifo_almost_empty, core_out_valid, core_out_data,
               out_fifo_almost_full, out_fifo_full,
        input  in_fifo_rd_en, core_in_valid, core_in_start, core_in_data, out_fifo_wr_en,
               out_fifo_din, busy, batch_count, err_overflow, err_protocol
    );

    // slave: the scheduler itself
    modport slave (
        input  enable, in_fifo_dout, in_fifo_almost_empty, core_out_valid, core_out_data,
               out_fifo_almost_full, out_fifo_full,
        output in_fifo_rd_en, core_in_valid, core_in_start, core_in_data, out_fifo_wr_en,
               out_fifo_din, busy, batch_count, err_overflow, err_protocol
    );

endinterface

// File: rtl/lyra2_batch_sched.sv
// rtl/lyra2_batch_sched.sv - issues full PIPELINE_DEPTH batches to the Lyra2 core and
// forwards the results to the output FIFO through one register stage
module lyra2_batch_sched
    import lyra2_pkg::*;
#(
    parameter int PIPELINE_DEPTH = lyra2_pkg::PIPELINE_DEPTH,
    parameter int DATA_WIDTH     = lyra2_pkg::DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    lyra2_batch_sched_if.slave bus
);

    localparam int              CNT_W = $clog2(PIPELINE_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIPELINE_DEPTH - 1);

    sched_state_e          state_q;
    logic [CNT_W-1:0]      issue_cnt_q;
    logic [CNT_W-1:0]      result_cnt_q;
    logic                  rd_en_q;
    logic                  in_valid_q;
    logic                  in_start_q;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  busy_q;
    logic [31:0]           batch_cnt_q;
    logic                  err_ovf_q;
    logic                  err_proto_q;

    logic start_ok;
    logic result_hit;
    logic result_last;

    // Both FIFO thresholds must clear so the whole batch can be read and written without stalls.
    assign start_ok    = bus.enable && !bus.in_fifo_almost_empty && !bus.out_fifo_almost_full;
    assign result_hit  = bus.core_out_valid && (state_q != ST_IDLE);
    assign result_last = result_hit && (result_cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= '0;
            result_cnt_q <= '0;
            rd_en_q      <= 1'b0;
            in_valid_q   <= 1'b0;
            in_start_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            busy_q       <= 1'b0;
            batch_cnt_q  <= '0;
            err_ovf_q    <= 1'b0;
            err_proto_q  <= 1'b0;
        end else begin
            // FIFO read data lands one cycle after rd_en, so valid/start trail the strobe.
            in_valid_q <= rd_en_q;
            in_start_q <= (state_q == ST_LOAD) && (issue_cnt_q == '0);

            wr_en_q <= result_hit;
            if (result_hit) begin
                din_q <= bus.core_out_data;
            end
            if (bus.core_out_valid && (state_q == ST_IDLE)) begin
                err_proto_q <= 1'b1;
            end
            if (wr_en_q && bus.out_fifo_full) begin
                err_ovf_q <= 1'b1;
            end

            if (result_last) begin
                result_cnt_q <= '0;
                batch_cnt_q  <= batch_cnt_q + 32'd1;
            end else if (result_hit) begin
                result_cnt_q <= result_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q     <= ST_LOAD;
                        rd_en_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        issue_cnt_q <= '0;
                    end
                end
                ST_LOAD: begin
                    if (issue_cnt_q == LAST) begin
                        state_q     <= ST_WAIT;
                        rd_en_q     <= 1'b0;
                        issue_cnt_q <= '0;
                    end else begin
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (result_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_fifo_rd_en  = rd_en_q;
    assign bus.core_in_valid  = in_valid_q;
    assign bus.core_in_start  = in_start_q;
    assign bus.core_in_data   = in_valid_q ? bus.in_fifo_dout : '0;
    assign bus.out_fifo_wr_en = wr_en_q;
    assign bus.out_fifo_din   = din_q;
    assign bus.busy           = busy_q;
    assign bus.batch_count    = batch_cnt_q;
    assign bus.err_overflow   = err_ovf_q;
    assign bus.err_protocol   = err_proto_q;

endmodule

// File: tb/tb_lyra2_batch_sched.sv
// tb/tb_lyra2_batch_sched.sv - directed bench with FIFO/core models and a result scoreboard
module tb_lyra2_batch_sched;
    import lyra2_pkg::*;

    localparam int D  = PIPELINE_DEPTH;
    localparam int DW = DATA_WIDTH;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } core_item_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lyra2_batch_sched_if #(.DATA_WIDTH(DW)) bus ();

    lyra2_batch_sched #(.PIPELINE_DEPTH(D), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] inq[$];
    logic [DW-1:0] expq[$];
    core_item_t    coreq[$];
    int            rd_cycles[$];
    int            rd_cnt, start_cnt, start_cyc, wr_cnt, last_wr_cyc;
    logic [DW-1:0] start_data;
    logic [31:0]   bc_at_last_wr;
    logic          force_cv;
    int            s, b1_last_wr;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rd_cycles.delete();
        rd_cnt = 0; start_cnt = 0; start_cyc = -1; wr_cnt = 0; last_wr_cyc = -1;
        start_data = '0; bc_at_last_wr = '0;
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            inq.push_back(base + DW'(i));
            expq.push_back(base + DW'(i) + DW'('h100));
        end
        bus.in_fifo_almost_empty = (inq.size() < D);
    endtask

    // One clock: sample DUT at the falling edge, then update FIFO/core models for the next cycle.
    task automatic tick();
        logic          rd, iv, st, wr;
        logic [DW-1:0] id, wd, e;
        core_item_t    c;
        @(negedge clk);
        cyc++;
        rd = bus.in_fifo_rd_en; iv = bus.core_in_valid; st = bus.core_in_start;
        id = bus.core_in_data;  wr = bus.out_fifo_wr_en; wd = bus.out_fifo_din;
        if (rd) begin
            rd_cnt++;
            rd_cycles.push_back(cyc);
            if (inq.size() > 0) bus.in_fifo_dout = inq.pop_front();
        end
        if (st) begin
            start_cnt++; start_cyc = cyc; start_data = id;
        end
        if (iv && rst_n) coreq.push_back('{cyc + 20, id + DW'('h100)});
        if (wr) begin
            wr_cnt++; last_wr_cyc = cyc; bc_at_last_wr = bus.batch_count;
            e = (expq.size() > 0) ? expq.pop_front() : '1;
            check("out_data", wd, e);
        end
        if (!rst_n) coreq.delete();
        bus.core_out_valid = force_cv;
        bus.core_out_data  = '0;
        if (coreq.size() > 0 && coreq[0].due <= cyc + 1) begin
            c = coreq.pop_front();
            bus.core_out_valid = 1'b1;
            bus.core_out_data  = c.d;
        end
        bus.in_fifo_almost_empty = (inq.size() < D);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, bus.in_fifo_rd_en, 0);
        check({tag, "_in_valid"}, bus.core_in_valid, 0);
        check({tag, "_in_start"}, bus.core_in_start, 0);
        check({tag, "_wr_en"}, bus.out_fifo_wr_en, 0);
        check({tag, "_din"}, bus.out_fifo_din, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_batch_count"}, bus.batch_count, 0);
        check({tag, "_err_ovf"}, bus.err_overflow, 0);
        check({tag, "_err_proto"}, bus.err_protocol, 0);
    endtask

    initial begin
        rst_n = 1'b0; bus.enable = 1'b0; bus.in_fifo_dout = '0; bus.in_fifo_almost_empty = 1'b1;
        bus.core_out_valid = 1'b0; bus.core_out_data = '0;
        bus.out_fifo_almost_full = 1'b0; bus.out_fifo_full = 1'b0; force_cv = 1'b0;
        clear_stats();
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic batch: 8 words, timing of read strobes, start flag and completion.
        clear_stats();
        load(D, 'h1);
        bus.enable = 1'b1;
        s = cyc;
        tick(); tick();
        check("t1_busy_loading", bus.busy, 1);
        for (int i = 0; i < 300 && bus.batch_count != 1; i++) tick();
        check("t1_batch_count", bus.batch_count, 1);
        check("t1_busy_done", bus.busy, 0);
        check("t1_rd_count", rd_cnt, D);
        check("t1_first_rd", (rd_cycles.size() > 0) ? rd_cycles[0] : -1, s + 1);
        check("t1_last_rd", (rd_cycles.size() > 0) ? rd_cycles[rd_cycles.size()-1] : -1, s + D);
        check("t1_start_cnt", start_cnt, 1);
        check("t1_start_cyc", start_cyc, s + 2);
        check("t1_start_data", start_data, 'h1);
        check("t1_wr_count", wr_cnt, D);
        check("t1_bc_with_last_wr", bc_at_last_wr, 1);
        check("t1_sb_drained", expq.size(), 0);

        // Seven words only: input almost-empty holds the scheduler idle.
        clear_stats();
        load(D - 1, 'h11);
        repeat (100) tick();
        check("t2_no_rd", rd_cnt, 0);
        check("t2_busy", bus.busy, 0);
        inq.delete(); expq.delete();
        tick();

        // Two batches with output almost-full raised after batch 1 issue.
        clear_stats();
        load(2 * D, 'h21);
        for (int i = 0; i < 50 && rd_cnt < D; i++) tick();
        bus.out_fifo_almost_full = 1'b1;
        for (int i = 0; i < 300 && bus.batch_count != 2; i++) tick();
        check("t3_b1_done", bus.batch_count, 2);
        check("t3_b1_writes", wr_cnt, D);
        b1_last_wr = last_wr_cyc;
        repeat (30) tick();
        check("t3_held_by_af", rd_cnt, D);
        bus.out_fifo_almost_full = 1'b0;
        for (int i = 0; i < 300 && bus.batch_count != 3; i++) tick();
        check("t3_b2_done", bus.batch_count, 3);
        check("t3_total_writes", wr_cnt, 2 * D);
        check("t3_gap", (rd_cycles.size() > D) ? (rd_cycles[D] - b1_last_wr >= 2) : 0, 1);

        // enable dropped in the third LOAD cycle: batch still completes, none follows.
        clear_stats();
        load(D, 'h41);
        for (int i = 0; i < 50 && rd_cnt < 3; i++) tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 300 && bus.batch_count != 4; i++) tick();
        check("t4_batch_count", bus.batch_count, 4);
        check("t4_reads", rd_cnt, D);
        check("t4_writes", wr_cnt, D);
        load(D, 'h51);
        repeat (60) tick();
        check("t4_no_new_rd", rd_cnt, D);
        check("t4_busy", bus.busy, 0);
        inq.delete(); expq.delete();
        tick();

        // Sticky error flags and their clear by reset.
        clear_stats();
        force_cv = 1'b1; tick(); force_cv = 1'b0; tick(); tick();
        check("t5_err_proto", bus.err_protocol, 1);
        check("t5_no_write", wr_cnt, 0);
        check("t5_no_ovf_yet", bus.err_overflow, 0);
        bus.out_fifo_full = 1'b1;
        bus.enable = 1'b1;
        load(D, 'h61);
        for (int i = 0; i < 300 && bus.batch_count != 5; i++) tick();
        check("t5_batch_count", bus.batch_count, 5);
        check("t5_writes_issued", wr_cnt, D);
        check("t5_err_ovf", bus.err_overflow, 1);
        bus.out_fifo_full = 1'b0;
        repeat (10) tick();
        check("t5_ovf_sticky", bus.err_overflow, 1);
        check("t5_proto_sticky", bus.err_protocol, 1);
        rst_n = 1'b0;
        tick();
        check("t5_ovf_cleared", bus.err_overflow, 0);
        check("t5_proto_cleared", bus.err_protocol, 0);
        check("t5_bc_cleared", bus.batch_count, 0);
        rst_n = 1'b1;
        tick();

        // Reset in WAIT after three results, then a clean batch.
        clear_stats();
        load(D, 'h71);
        for (int i = 0; i < 300 && wr_cnt < 3; i++) tick();
        check("t6_results_before_rst", wr_cnt, 3);
        check("t6_busy_before_rst", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("t6_rst");
        expq.delete();
        rst_n = 1'b1;
        repeat (5) tick();
        clear_stats();
        load(D, 'h81);
        for (int i = 0; i < 300 && bus.batch_count != 1; i++) tick();
        check("t6_fresh_bc", bus.batch_count, 1);
        check("t6_fresh_writes", wr_cnt, D);
        check("t6_fresh_start_data", start_data, 'h81);
        check("t6_sb_drained", expq.size(), 0);
        check("t6_no_proto", bus.err_protocol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lyra2_batch_sched.md
# lyra2_batch_sched

Batch scheduler between the input hash FIFO, the Lyra2 core and the output hash FIFO. Issues hashes to the core only in full batches of PIPELINE_DEPTH, so every interleaved pipeline slot is filled. It then forwards the PIPELINE_DEPTH results into the output FIFO through a registered stage. Batch issue and completion are exposed to the AXI register block as status.

## Interface
Parameters:
- PIPELINE_DEPTH, 8, hashes per batch; matches the core's interleave depth.
- DATA_WIDTH, 256, hash width.

Ports:
- clk  in  1  system clock; the block has one clock.
- rst_n  in  1  reset, synchronous and active-low.
- enable  in  1  AXI control bit; gates the start of new batches only.
- in_fifo_dout  in  DATA_WIDTH  input FIFO read data; standard mode, valid 1 cycle after rd_en.
- in_fifo_almost_empty  in  1  high when fewer than PIPELINE_DEPTH words are stored.
- in_fifo_rd_en  out  1  input FIFO read strobe.
- core_in_valid  out  1  hash valid to the core.
- core_in_start  out  1  marks the first hash of a batch.
- core_in_data  out  DATA_WIDTH  hash to the core.
- core_out_valid  in  1  result valid from the core.
- core_out_data  in  DATA_WIDTH  result from the core.
- out_fifo_almost_full  in  1  high when free space is less than PIPELINE_DEPTH.
- out_fifo_full  in  1  output FIFO full.
- out_fifo_wr_en  out  1  output FIFO write strobe.
- out_fifo_din  out  DATA_WIDTH  output FIFO write data.
- busy  out  1  high outside IDLE.
- batch_count  out  32  number of completed batches; wraps at 2^32.
- err_overflow  out  1  sticky; set by a write while out_fifo_full.
- err_protocol  out  1  sticky; set by core_out_valid in IDLE.

## Operation
- States: IDLE, LOAD, WAIT.
- IDLE → LOAD when enable && !in_fifo_almost_empty && !out_fifo_almost_full. This guarantees the input data and output space for the whole batch before issue.
- LOAD:
  - Assert in_fifo_rd_en for exactly PIPELINE_DEPTH consecutive cycles, using issue counter 0..PIPELINE_DEPTH-1.
  - Then go to WAIT.
- Core input path: core_in_valid and core_in_data = in_fifo_dout one cycle after each rd_en. core_in_start accompanies the first word only.
- Result path:
  - Every core_out_valid outside IDLE is registered into out_fifo_din, with out_fifo_wr_en one cycle later.
  - Results are counted 0..PIPELINE_DEPTH-1 and may arrive during LOAD.
- WAIT → IDLE on the PIPELINE_DEPTH-th result. batch_count increments in the cycle that result's out_fifo_wr_en asserts.
- core_out_valid in IDLE:
  - Sets err_protocol.
  - The result is dropped; no write occurs.
- A write while out_fifo_full sets err_overflow. The write strobe is still issued; the FIFO discards it.
- enable deasserted mid-batch: the batch completes normally; no new batch starts.
- Errors clear only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, both counters 0.
- Reset mid-batch: the same values apply on the next edge. FIFO contents are not touched; in-flight core results arriving after reset set err_protocol.
- Start condition true at cycle 0:
  - LOAD in cycle 1.
  - in_fifo_rd_en high in cycles 1..PIPELINE_DEPTH.
  - core_in_valid high in cycles 2..PIPELINE_DEPTH+1; core_in_start high in cycle 2.
  - WAIT from cycle PIPELINE_DEPTH+1.
- Result latency: core_out_valid at cycle k → out_fifo_wr_en at cycle k+1.
- Final result at cycle k:
  - State IDLE, busy low and batch_count+1 at cycle k+1.
  - The earliest next rd_en is cycle k+2; at least one IDLE cycle always separates batches.
- Start condition inputs are sampled only in IDLE. Changes during LOAD/WAIT have no effect.

## Structure
- Shared package lyra2_pkg holds:
  - The state enum typedef.
  - DATA_WIDTH.
  - PIPELINE_DEPTH, which is also the board package value.
  - The almost-empty/almost-full thresholds, derived from PIPELINE_DEPTH.
- No sub-module: the FSM, the two $clog2(PIPELINE_DEPTH+1)-bit counters and the output register are inline.

## Test plan
- Input FIFO model holding 8 words 0x1..0x8, output FIFO empty, enable=1 → rd_en cycles 1–8, core_in_start with 0x1 at cycle 2, busy=1. A core model returning x+0x100 after 20 cycles → out_fifo writes 0x101..0x108 in order, batch_count=1, busy=0.
- Input FIFO holding 7 words (almost_empty=1), enable=1 → no rd_en for 100 cycles, busy=0.
- 16 words, out_fifo_almost_full toggled high after batch 1 issue → batch 1 completes (8 writes). Batch 2 starts only after almost_full drops; the gap between the batch 1 final write and the batch 2 first rd_en is ≥1 cycle.
- enable dropped in cycle 3 of LOAD → all 8 reads and 8 writes complete, batch_count=1, no further rd_en.
- core_out_valid pulsed in IDLE → err_protocol=1, no write. A write with out_fifo_full=1 → err_overflow=1. Both stay set until rst_n=0, which clears them in 1 cycle.
- rst_n asserted in WAIT after 3 results → next cycle all outputs 0 and batch_count=0. A fresh batch afterwards runs normally.
